// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: credit-limited requests, pc-tag queue, in-order instruction buffer
module ifetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo-DEPTH wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
endmodule

module ifetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  input  logic        out_ready
);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
    $error("ifetch_unit: DEPTH must be 2 or 4");
  end

  logic [31:0]   fpc;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] stale_cnt;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_keep;
  logic          deq;
  logic [31:0]   tag_pc;
  logic [63:0]   head_entry;
  logic          redirect_pc_unused;

  // Stale requests still hold a credit until their response drains
  assign credit_used      = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req_valid   = !reset && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr    = fpc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign resp_fire        = imem_resp_valid && (outstanding != '0);
  assign resp_keep        = resp_fire && (stale_cnt == '0) && !redirect;
  assign deq              = out_valid && out_ready && !redirect;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);

  ifetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fpc),
    .pop       (resp_fire),
    .head_data (tag_pc),
    .count     (outstanding)
  );

  ifetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data ({tag_pc, imem_resp_data}),
    .pop       (deq),
    .head_data (head_entry),
    .count     (occupancy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc       <= RESET_VECTOR;
      stale_cnt <= '0;
    end else if (redirect) begin
      fpc       <= {redirect_pc[31:2], 2'b00};
      stale_cnt <= outstanding_next;
    end else begin
      if (req_fire) fpc <= fpc + 32'd4;
      if (resp_fire && stale_cnt != '0) stale_cnt <= stale_cnt - CW'(1);
    end
  end

  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign out_valid    = (occupancy != '0);
  assign out_pc       = head_entry[63:32];
  assign out_instr    = head_entry[31:0];
  assign out_pc_plus4 = out_pc + 32'd4;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - randomized and scenario bench for ifetch_unit against a fetch-stream model
module tb_ifetch_unit;
  localparam logic [31:0] RV    = 32'h80000000;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_ready;

  int total;
  int bad;

  ifetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .out_ready       (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: in-order queue of accepted addresses tagged with issue cycle and fetch generation
  logic [31:0] memq_addr [$];
  int          memq_cyc  [$];
  int          memq_gen  [$];
  int          gen;
  int          cyc;
  int          buffered;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;

  logic        obs_req_valid, obs_accept, obs_out_valid, obs_consume;
  logic [31:0] obs_req_addr, obs_out_instr, obs_out_pc, obs_out_pc4;
  logic        obs_exp_req_valid, obs_exp_out_valid;
  logic [31:0] obs_exp_pc, obs_exp_req;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A55A3C;
  endfunction

  task automatic model_reset();
    memq_addr.delete();
    memq_cyc.delete();
    memq_gen.delete();
    buffered = 0;
    gen      = gen + 1;
    exp_pc   = RV;
    exp_req  = RV;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample settled outputs, advance the model, cross the posedge
  task automatic tick(input logic rdy, input logic ordy, input logic redir, input logic [31:0] rpc,
                      input logic mem_en, input logic junk);
    logic resp_pop;
    logic kept;
    imem_req_ready  = rdy;
    out_ready       = ordy;
    redirect        = redir;
    redirect_pc     = rpc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    resp_pop        = 1'b0;
    if (mem_en && memq_addr.size() > 0 && memq_cyc[0] < cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(memq_addr[0]);
      resp_pop        = 1'b1;
    end else if (junk && memq_addr.size() == 0) begin
      imem_resp_valid = 1'b1;
    end
    #1;
    obs_req_valid     = imem_req_valid;
    obs_req_addr      = imem_req_addr;
    obs_accept        = imem_req_valid && rdy;
    obs_out_valid     = out_valid;
    obs_out_instr     = out_instr;
    obs_out_pc        = out_pc;
    obs_out_pc4       = out_pc_plus4;
    obs_consume       = out_valid && ordy;
    obs_exp_req_valid = (memq_addr.size() + buffered) < DEPTH;
    obs_exp_out_valid = buffered > 0;
    obs_exp_pc        = exp_pc;
    obs_exp_req       = exp_req;
    kept = 1'b0;
    if (resp_pop) begin
      kept = (memq_gen[0] == gen) && !redir;
      void'(memq_addr.pop_front());
      void'(memq_cyc.pop_front());
      void'(memq_gen.pop_front());
    end
    if (obs_accept) begin
      memq_addr.push_back(imem_req_addr);
      memq_cyc.push_back(cyc);
      memq_gen.push_back(gen);
      exp_req = exp_req + 32'd4;
    end
    if (redir) begin
      gen      = gen + 1;
      buffered = 0;
      exp_pc   = {rpc[31:2], 2'b00};
      exp_req  = {rpc[31:2], 2'b00};
    end else begin
      buffered = buffered + int'(kept) - int'(obs_consume);
      if (obs_consume) exp_pc = exp_pc + 32'd4;
    end
    cyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, RV}) begin bad++; $display("FAIL reset_first_req: got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RV); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    total++; if ({obs_accept, obs_req_addr} !== {1'b1, RV}) begin bad++; $display("FAIL stream_req0: got %b/%h want 1/%h", obs_accept, obs_req_addr, RV); end
    total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL stream_ov0: got %b want 0", obs_out_valid); end
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    total++; if ({obs_accept, obs_req_addr} !== {1'b1, RV + 32'd4}) begin bad++; $display("FAIL stream_req1: got %b/%h want 1/%h", obs_accept, obs_req_addr, RV + 32'd4); end
    total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL stream_ov1: got %b want 0", obs_out_valid); end
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    total++; if ({obs_out_valid, obs_out_pc, obs_out_pc4} !== {1'b1, RV, RV + 32'd4}) begin bad++; $display("FAIL stream_first_out: got %b/%h/%h want 1/%h/%h", obs_out_valid, obs_out_pc, obs_out_pc4, RV, RV + 32'd4); end
    total++; if (obs_out_instr !== instr_of(RV)) begin bad++; $display("FAIL stream_first_instr: got %h want %h", obs_out_instr, instr_of(RV)); end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (obs_accept) begin
        total++; if (obs_req_addr !== obs_exp_req) begin bad++; $display("FAIL stream_req_addr: got %h want %h", obs_req_addr, obs_exp_req); end
      end
      if (obs_out_valid) begin
        total++; if ({obs_out_pc, obs_out_pc4} !== {obs_exp_pc, obs_exp_pc + 32'd4}) begin bad++; $display("FAIL stream_out_pc: got %h/%h want %h/%h", obs_out_pc, obs_out_pc4, obs_exp_pc, obs_exp_pc + 32'd4); end
      end
    end
  endtask

  task automatic test_stall();
    int accepts;
    int consumes;
    accepts  = 0;
    consumes = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      accepts += int'(obs_accept);
    end
    total++; if (accepts !== DEPTH) begin bad++; $display("FAIL stall_accepts: got %0d want %0d", accepts, DEPTH); end
    total++; if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", obs_req_valid); end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (obs_consume) begin
        consumes++;
        total++; if (obs_out_pc !== obs_exp_pc) begin bad++; $display("FAIL stall_resume_pc: got %h want %h", obs_out_pc, obs_exp_pc); end
      end
    end
    total++; if (consumes < 4) begin bad++; $display("FAIL stall_resume_count: got %0d want >=4", consumes); end
  endtask

  task automatic test_redirect();
    logic seen_out, seen_req;
    seen_out = 1'b0;
    seen_req = 1'b0;
    do_reset();
    tick(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 32'h80000100, 1'b0, 1'b0);
    total++; if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL redir_credit_full: got %b want 0", obs_req_valid); end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (obs_accept && !seen_req) begin
        seen_req = 1'b1;
        total++; if (obs_req_addr !== 32'h80000100) begin bad++; $display("FAIL redir_first_req: got %h want 80000100", obs_req_addr); end
      end
      if (obs_consume && !seen_out) begin
        seen_out = 1'b1;
        total++; if ({obs_out_pc, obs_out_instr} !== {32'h80000100, instr_of(32'h80000100)}) begin bad++; $display("FAIL redir_first_out: got %h/%h want 80000100/%h", obs_out_pc, obs_out_instr, instr_of(32'h80000100)); end
      end
    end
    total++; if (!seen_out) begin bad++; $display("FAIL redir_delivery: got none want 80000100"); end
  endtask

  task automatic test_redirect_same_cycle();
    logic seen_out;
    seen_out = 1'b0;
    do_reset();
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 32'h80000200, 1'b1, 1'b0);
    total++; if (obs_accept !== 1'b1) begin bad++; $display("FAIL same_cycle_accept: got %b want 1", obs_accept); end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (obs_consume && !seen_out) begin
        seen_out = 1'b1;
        total++; if (obs_out_pc !== 32'h80000200) begin bad++; $display("FAIL same_cycle_first_out: got %h want 80000200", obs_out_pc); end
      end
    end
    total++; if (!seen_out) begin bad++; $display("FAIL same_cycle_delivery: got none want 80000200"); end
  endtask

  task automatic test_misaligned();
    logic seen_req;
    seen_req = 1'b0;
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 32'h80000102, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (obs_accept && !seen_req) begin
        seen_req = 1'b1;
        total++; if (obs_req_addr !== 32'h80000100) begin bad++; $display("FAIL misaligned_req: got %h want 80000100", obs_req_addr); end
      end
    end
    total++; if (!seen_req) begin bad++; $display("FAIL misaligned_no_req: got none want 80000100"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    total++; if ({out_valid, imem_req_valid} !== 2'b10) begin bad++; $display("FAIL mid_full: got ov=%b rv=%b want ov=1 rv=0", out_valid, imem_req_valid); end
    reset = 1'b1;
    #1;
    total++; if ({out_valid, imem_req_valid} !== 2'b00) begin bad++; $display("FAIL mid_async: got ov=%b rv=%b want 0/0", out_valid, imem_req_valid); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    total++; if ({obs_accept, obs_req_addr} !== {1'b1, RV}) begin bad++; $display("FAIL mid_first_req: got %b/%h want 1/%h", obs_accept, obs_req_addr, RV); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rd, ord, rdr, me, jk;
      logic [31:0] rpc;
      rd  = ($urandom_range(3) != 0);
      ord = ($urandom_range(2) != 0);
      rdr = ($urandom_range(39) == 0);
      me  = ($urandom_range(2) != 0);
      jk  = ($urandom_range(1) == 1);
      rpc = ($urandom_range(3) == 0) ? {28'hFFFFFFF, 4'($urandom)} : {16'h8000, 16'($urandom)};
      tick(rd, ord, rdr, rpc, me, jk);
      total++; if (obs_req_valid !== obs_exp_req_valid) begin bad++; $display("FAIL rnd_req_valid: cycle %0d got %b want %b", cyc, obs_req_valid, obs_exp_req_valid); end
      total++; if (obs_out_valid !== obs_exp_out_valid) begin bad++; $display("FAIL rnd_out_valid: cycle %0d got %b want %b", cyc, obs_out_valid, obs_exp_out_valid); end
      if (obs_accept) begin
        total++; if (obs_req_addr !== obs_exp_req) begin bad++; $display("FAIL rnd_req_addr: cycle %0d got %h want %h", cyc, obs_req_addr, obs_exp_req); end
      end
      if (obs_out_valid) begin
        total++; if ({obs_out_pc, obs_out_pc4, obs_out_instr} !== {obs_exp_pc, obs_exp_pc + 32'd4, instr_of(obs_exp_pc)}) begin
          bad++; $display("FAIL rnd_out: cycle %0d got %h/%h/%h want %h/%h/%h", cyc, obs_out_pc, obs_out_pc4, obs_out_instr, obs_exp_pc, obs_exp_pc + 32'd4, instr_of(obs_exp_pc));
        end
      end
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    gen             = 0;
    cyc             = 0;
    buffered        = 0;
    exp_pc          = RV;
    exp_req         = RV;
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
